// File: rtl/wb_regfile_if.sv
// Writeback-side bus of the register file: the write port driven by the
// MEM/WB stage, the two decode read ports, the debug port and status.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWriteW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;
  logic [15:0]       WriteCount;
  logic [ADDR_W-1:0] LastWriteReg;

  // Pipeline side: drives writeback and read indices, receives read data.
  modport master (
    output RegWriteW, WriteRegW, ResultW, A1, A2, DbgAddr,
    input  RD1, RD2, DbgData, WriteCount, LastWriteReg
  );

  // Register file side.
  modport slave (
    input  RegWriteW, WriteRegW, ResultW, A1, A2, DbgAddr,
    output RD1, RD2, DbgData, WriteCount, LastWriteReg
  );
endinterface

// File: rtl/wb_regfile.sv
// Register file fed by the writeback bus. Two decode read ports with a
// same-cycle write-to-read bypass, a non-bypassed debug read port, and
// commit statistics (saturating write count, last written index).
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_regfile_if.slave   bus
);

  localparam int NREGS   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [15:0]       write_count_q, write_count_d;
  logic [ADDR_W-1:0] last_write_reg_q;
  logic              commit;

  // Index 0 is hard-wired when ZERO_EN, so such writes are dropped outright.
  // RegWriteW gates everything, so an undefined WriteRegW while idle is harmless.
  assign commit = bus.RegWriteW && ((bus.WriteRegW != '0) || !ZERO_EN);

  // Saturating increment of the commit counter.
  always_comb begin
    write_count_d = write_count_q;
    if (write_count_q != 16'hFFFF) write_count_d = write_count_q + 16'd1;
  end

  // Array and statistics update on commit; async reset clears everything.
  // NOTE: the storage array is reset on purpose -- the architectural state must
  // read as zero straight out of reset, so this stays flops rather than a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      write_count_q    <= '0;
      last_write_reg_q <= '0;
    end else if (commit) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge
      // values; blocking ones would make ordering inside this block matter.
      regs_q[bus.WriteRegW] <= bus.ResultW;
      write_count_q         <= write_count_d;
      last_write_reg_q      <= bus.WriteRegW;
    end
  end

  // Decode read: zero register first, then bypass, then stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (ZERO_EN && (addr == '0))       return '0;
    else if (wr_en && (wr_addr == addr)) return wr_data;
    else                                 return stored;
  endfunction

  // Both decode ports, evaluated combinationally.
  always_comb begin
    bus.RD1 = read_port(bus.A1, bus.RegWriteW, bus.WriteRegW, bus.ResultW, regs_q[bus.A1]);
    bus.RD2 = read_port(bus.A2, bus.RegWriteW, bus.WriteRegW, bus.ResultW, regs_q[bus.A2]);
  end

  // Debug read shows committed state only, never the in-flight write.
  always_comb begin
    bus.DbgData = regs_q[bus.DbgAddr];
    if (ZERO_EN && (bus.DbgAddr == '0)) bus.DbgData = '0;
  end

  assign bus.WriteCount   = write_count_q;
  assign bus.LastWriteReg = last_write_reg_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: expected values are queued when the
// stimulus is applied and compared against the DUT when drained.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_RD1, S_RD2, S_DBG, S_CNT, S_LAST} sel_e;
  typedef struct {
    sel_e        sel;
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input sel_e sel, input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.sel = sel;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  // Compare every queued expectation against the DUT output it names.
  task automatic drain();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sel)
        S_RD1:   obs = bus.RD1;
        S_RD2:   obs = bus.RD2;
        S_DBG:   obs = bus.DbgData;
        S_CNT:   obs = {16'h0, bus.WriteCount};
        S_LAST:  obs = {27'h0, bus.LastWriteReg};
        default: obs = '0;
      endcase
      check(it.tag, obs, it.exp);
    end
  endtask

  task automatic expect_stats(input string tag, input logic [15:0] cnt, input logic [4:0] last);
    expect_out(S_CNT,  {tag, "_cnt"},  {16'h0, cnt});
    expect_out(S_LAST, {tag, "_last"}, {27'h0, last});
  endtask

  // One committed write: drive on the falling edge, release after the rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = a;
    bus.ResultW   = d;
    @(posedge clk);
    #1;
    bus.RegWriteW = 1'b0;
    bus.WriteRegW = 'x;
    bus.ResultW   = 'x;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.WriteRegW = '0;
    bus.ResultW   = '0;
    bus.A1        = '0;
    bus.A2        = '0;
    bus.DbgAddr   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i); bus.A2 = 5'(i); bus.DbgAddr = 5'(i);
      #1;
      expect_out(S_RD1, $sformatf("rst_rd1_%0d", i), 32'h0);
      expect_out(S_RD2, $sformatf("rst_rd2_%0d", i), 32'h0);
      expect_out(S_DBG, $sformatf("rst_dbg_%0d", i), 32'h0);
      drain();
    end
    expect_stats("rst", 16'd0, 5'd0);
    drain();

    // Same-cycle bypass of a write to reg 8, then committed state.
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd8; bus.ResultW = 32'hDEADBEEF;
    bus.A1 = 5'd8; bus.DbgAddr = 5'd8;
    #1;
    expect_out(S_RD1, "byp8_rd1", 32'hDEADBEEF);
    expect_out(S_DBG, "byp8_dbg_pre", 32'h0);
    expect_stats("byp8_pre", 16'd0, 5'd0);
    drain();
    @(posedge clk); #1;
    bus.RegWriteW = 1'b0; bus.WriteRegW = 'x; bus.ResultW = 'x;
    #1;
    expect_out(S_DBG, "byp8_dbg_post", 32'hDEADBEEF);
    expect_out(S_RD1, "byp8_rd1_post", 32'hDEADBEEF);
    expect_stats("byp8_post", 16'd1, 5'd8);
    drain();

    // Write to reg 0 is ignored everywhere.
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd0; bus.ResultW = 32'h12345678;
    bus.A1 = 5'd0; bus.DbgAddr = 5'd0;
    #1;
    expect_out(S_RD1, "zero_rd1_pre", 32'h0);
    drain();
    @(posedge clk); #1;
    bus.RegWriteW = 1'b0;
    #1;
    expect_out(S_RD1, "zero_rd1_post", 32'h0);
    expect_out(S_DBG, "zero_dbg_post", 32'h0);
    expect_stats("zero_post", 16'd1, 5'd8);
    drain();

    // Dual-port bypass on reg 5, then bypass disabled with RegWriteW low.
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd5; bus.ResultW = 32'hA5A5A5A5;
    bus.A1 = 5'd5; bus.A2 = 5'd5;
    #1;
    expect_out(S_RD1, "dual5_rd1", 32'hA5A5A5A5);
    expect_out(S_RD2, "dual5_rd2", 32'hA5A5A5A5);
    drain();
    @(negedge clk);
    bus.RegWriteW = 1'b0; bus.WriteRegW = 5'd5; bus.ResultW = 32'h0;
    #1;
    expect_out(S_RD1, "idle5_rd1", 32'hA5A5A5A5);
    expect_out(S_RD2, "idle5_rd2", 32'hA5A5A5A5);
    drain();
    bus.WriteRegW = 5'd6; bus.ResultW = 32'h0000F00D; bus.A1 = 5'd6;
    #1;
    expect_out(S_RD1, "idle6_rd1", 32'h0);
    drain();
    @(posedge clk); #1;
    bus.DbgAddr = 5'd6;
    #1;
    expect_out(S_DBG, "idle6_dbg", 32'h0);
    expect_stats("idle", 16'd2, 5'd5);
    drain();

    // Back-to-back writes to reg 3: bypass shows the new value, debug the old.
    do_write(5'd3, 32'd1);
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd3; bus.ResultW = 32'd2;
    bus.A1 = 5'd3; bus.A2 = 5'd8; bus.DbgAddr = 5'd3;
    #1;
    expect_out(S_RD1, "b2b3_rd1", 32'd2);
    expect_out(S_RD2, "b2b3_rd2_other", 32'hDEADBEEF);
    expect_out(S_DBG, "b2b3_dbg_pre", 32'd1);
    drain();
    @(posedge clk); #1;
    bus.RegWriteW = 1'b0;
    #1;
    expect_out(S_DBG, "b2b3_dbg_post", 32'd2);
    expect_stats("b2b3", 16'd4, 5'd3);
    drain();

    // Fill regs 1..31 with their index.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    for (int i = 0; i < 32; i += 5) begin
      bus.DbgAddr = 5'(i);
      #1;
      expect_out(S_DBG, $sformatf("fill_dbg_%0d", i), 32'(i));
      drain();
    end
    expect_stats("fill", 16'd35, 5'd31);
    drain();

    // Mid-cycle reset with a write in flight: clears at once, write is lost.
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd7; bus.ResultW = 32'hFFFFFFFF;
    bus.A1 = 5'd9; bus.A2 = 5'd20; bus.DbgAddr = 5'd31;
    #1;
    expect_out(S_RD1, "mid_rd1_pre", 32'd9);
    expect_out(S_DBG, "mid_dbg_pre", 32'd31);
    drain();
    #1 rst_n = 1'b0;
    #1;
    expect_out(S_RD1, "mid_rd1", 32'h0);
    expect_out(S_RD2, "mid_rd2", 32'h0);
    expect_out(S_DBG, "mid_dbg", 32'h0);
    expect_stats("mid", 16'd0, 5'd0);
    drain();
    @(posedge clk); #1;
    @(negedge clk);
    bus.RegWriteW = 1'b0;
    rst_n = 1'b1;
    bus.DbgAddr = 5'd7; bus.A1 = 5'd7;
    #1;
    expect_out(S_DBG, "rstwr_dbg7", 32'h0);
    expect_out(S_RD1, "rstwr_rd1", 32'h0);
    expect_stats("rstwr", 16'd0, 5'd0);
    drain();

    // Saturation of the write counter.
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd1; bus.ResultW = 32'h00000077;
    repeat (65534) @(posedge clk);
    #1;
    bus.RegWriteW = 1'b0;
    #1;
    expect_stats("sat_fffe", 16'hFFFE, 5'd1);
    drain();
    do_write(5'd2, 32'h22);
    #1;
    expect_stats("sat_ffff", 16'hFFFF, 5'd2);
    drain();
    do_write(5'd4, 32'h44);
    bus.DbgAddr = 5'd4;
    #1;
    expect_stats("sat_hold", 16'hFFFF, 5'd4);
    expect_out(S_DBG, "sat_dbg4", 32'h44);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
